// File: rtl/ram_burst_master.sv
// ============================================================================
// Module   : ram_burst_master
// Purpose  : Burst read/write initiator for a single-port RAM (negedge write,
//            combinational read). Optional command bound check is enabled
//            with the macro RAM_BURST_BOUND_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    // Command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [ADDR_WIDTH-1:0] cmd_length,
    // Write data channel
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    // Read data channel
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    // Status
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_error,
    // RAM side
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    output logic                  ram_chip_select,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR         = 3'd1,
        ST_RD_ISSUE   = 3'd2,
        ST_RD_CAPTURE = 3'd3,
        ST_RD_HOLD    = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cur_addr_q;
    logic [ADDR_WIDTH-1:0]   remaining_q;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_last_q;
    logic                    done_q;
    logic                    cmd_error_q;
    logic [ADDR_WIDTH-1:0]   ram_address_q;
    logic [DATA_WIDTH-1:0]   ram_data_in_q;
    logic                    ram_we_q;
    logic                    ram_chip_select_q;

    logic [ADDR_WIDTH-1:0]   cur_addr_d;
    logic [ADDR_WIDTH-1:0]   remaining_d;
    logic                    w_last;
    logic                    w_cmd_oob;

    assign cur_addr_d  = cur_addr_q + c_addr_one;
    assign remaining_d = remaining_q - c_addr_one;
    assign w_last      = (remaining_q == '0);

`ifdef RAM_BURST_BOUND_CHECK_EN
    // A carry out of the extended sum means the burst would run past the top word.
    logic [ADDR_WIDTH:0] w_bound_sum;
    assign w_bound_sum = {1'b0, cmd_address} + {1'b0, cmd_length};
    assign w_cmd_oob   = w_bound_sum[ADDR_WIDTH];
`else
    assign w_cmd_oob   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            cur_addr_q        <= '0;
            remaining_q       <= '0;
            rd_valid_q        <= 1'b0;
            rd_data_q         <= '0;
            rd_last_q         <= 1'b0;
            done_q            <= 1'b0;
            cmd_error_q       <= 1'b0;
            ram_address_q     <= '0;
            ram_data_in_q     <= '0;
            ram_we_q          <= 1'b0;
            ram_chip_select_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            cmd_error_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    ram_chip_select_q <= 1'b0;
                    ram_we_q          <= 1'b0;
                    if (cmd_valid && w_cmd_oob) begin
                        cmd_error_q <= 1'b1;
                    end else if (cmd_valid) begin
                        cur_addr_q  <= cmd_address;
                        remaining_q <= cmd_length;
                        state_q     <= cmd_we ? ST_WR : ST_RD_ISSUE;
                    end
                end

                ST_WR: begin
                    if (wr_valid) begin
                        ram_chip_select_q <= 1'b1;
                        ram_we_q          <= 1'b1;
                        ram_address_q     <= cur_addr_q;
                        ram_data_in_q     <= wr_data;
                        cur_addr_q        <= cur_addr_d;
                        if (w_last) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            remaining_q <= remaining_d;
                        end
                    end else begin
                        ram_chip_select_q <= 1'b0;
                        ram_we_q          <= 1'b0;
                    end
                end

                ST_RD_ISSUE: begin
                    ram_chip_select_q <= 1'b1;
                    ram_we_q          <= 1'b0;
                    ram_address_q     <= cur_addr_q;
                    state_q           <= ST_RD_CAPTURE;
                end

                // The RAM read path is combinational, so data for the address
                // registered in ST_RD_ISSUE is valid throughout this cycle.
                ST_RD_CAPTURE: begin
                    rd_data_q         <= ram_data_out;
                    rd_valid_q        <= 1'b1;
                    rd_last_q         <= w_last;
                    ram_chip_select_q <= 1'b0;
                    cur_addr_q        <= cur_addr_d;
                    state_q           <= ST_RD_HOLD;
                end

                ST_RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                        if (w_last) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            remaining_q <= remaining_d;
                            state_q     <= ST_RD_ISSUE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign wr_ready        = (state_q == ST_WR);
    assign busy            = (state_q != ST_IDLE);
    assign rd_valid        = rd_valid_q;
    assign rd_data         = rd_data_q;
    assign rd_last         = rd_last_q;
    assign done            = done_q;
    assign cmd_error       = cmd_error_q;
    assign ram_address     = ram_address_q;
    assign ram_data_in     = ram_data_in_q;
    assign ram_we          = ram_we_q;
    assign ram_chip_select = ram_chip_select_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_master.sv
// ============================================================================
// Module   : tb_ram_burst_master
// Purpose  : Self-checking bench for ram_burst_master with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_burst_master;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_address, cmd_length;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready, rd_last;
    logic [DW-1:0] rd_data;
    logic          busy, done, cmd_error;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in, ram_data_out;
    logic          ram_we, ram_chip_select;

    always #5 clock = ~clock;

    ram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_address(cmd_address), .cmd_length(cmd_length),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done), .cmd_error(cmd_error),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_we(ram_we),
        .ram_chip_select(ram_chip_select), .ram_data_out(ram_data_out)
    );

    // Behavioural 32x32 RAM: negedge write, combinational read
    logic [DW-1:0] mem [0:31];
    logic [DW-1:0] ref_mem [0:31];
    assign ram_data_out = mem[ram_address];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + i;
        forever begin
            @(negedge clock);
            if (ram_chip_select && ram_we) mem[ram_address] = ram_data_in;
        end
    end

    typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wexp_t;
    typedef struct packed {logic [DW-1:0] data; logic last;} rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];

    int checks = 0, failures = 0;
    int cyc = 0, wr_count = 0, rd_count = 0, cs_count = 0, done_count = 0, err_count = 0;
    int wr_cyc_hist [256];
    logic [DW-1:0] held_data;
    logic held_last;
    logic hold_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: pops the scoreboards when the DUT produces a write or read beat
    always @(negedge clock) begin
        if (!reset_n) begin
            hold_valid = 1'b0;
        end else begin
            if (ram_chip_select) cs_count++;
            if (ram_chip_select && ram_we) begin
                wr_cyc_hist[wr_count % 256] = cyc;
                wr_count++;
                if (wq.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    wexp_t e;
                    e = wq.pop_front();
                    check("wr_addr", ram_address, e.addr);
                    check("wr_data", ram_data_in, e.data);
                end
            end
            if (rd_valid) begin
                if (hold_valid) begin
                    check("rd_data_stable", rd_data, held_data);
                    check("rd_last_stable", rd_last, held_last);
                end
                if (rd_ready) begin
                    rd_count++;
                    hold_valid = 1'b0;
                    if (rq.size() == 0) check("rd_unexpected", 1, 0);
                    else begin
                        rexp_t r;
                        r = rq.pop_front();
                        check("rd_data", rd_data, r.data);
                        check("rd_last", rd_last, r.last);
                    end
                end else begin
                    held_data  = rd_data;
                    held_last  = rd_last;
                    hold_valid = 1'b1;
                end
            end else begin
                hold_valid = 1'b0;
            end
            if (done) done_count++;
            if (cmd_error) err_count++;
            if (done && cmd_error) check("done_err_exclusive", 1, 0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        check("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = we; cmd_address = a; cmd_length = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic [DW-1:0] seed,
                            input int gap, input int exp_beats, input int exp_span);
        int base, d0;
        logic [AW-1:0] ad;
        base = wr_count; d0 = done_count; ad = a;
        issue(1'b1, a, l);
        check("busy_wr", busy, 1);
        for (int i = 0; i <= int'(l); i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("gap_ram_we", ram_we, 0);
                end
            end
            check("wr_ready", wr_ready, 1);
            wr_valid = 1'b1;
            wr_data  = seed + i;
            wq.push_back({ad, seed + DW'(i)});
            ref_mem[ad] = seed + i;
            ad++;
            tick();
            wr_valid = 1'b0;
        end
        check("wr_done_pulse", done, 1);
        check("wr_busy_end", busy, 0);
        tick();
        check("wr_ram_we_after", ram_we, 0);
        check("wr_done_clear", done, 0);
        check("wr_beats", wr_count - base, exp_beats);
        check("wr_span", wr_cyc_hist[(base + exp_beats - 1) % 256] - wr_cyc_hist[base % 256], exp_span);
        check("wr_done_count", done_count - d0, 1);
        check("wq_empty", wq.size(), 0);
        ad = a;
        for (int i = 0; i <= int'(l); i++) begin
            check("mem_word", mem[ad], ref_mem[ad]);
            ad++;
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int stall, input int exp_beats);
        int d0, r0, n;
        logic [AW-1:0] ad;
        d0 = done_count; r0 = rd_count; ad = a;
        for (int i = 0; i <= int'(l); i++) begin
            rq.push_back({ref_mem[ad], (i == int'(l))});
            ad++;
        end
        issue(1'b0, a, l);
        n = 0;
        while (done_count == d0 && n < 200) begin
            rd_ready = (stall != 0) ? n[0] : 1'b1;
            tick();
            n++;
        end
        rd_ready = 1'b0;
        check("rd_timeout", (n < 200), 1);
        check("rd_done_count", done_count - d0, 1);
        check("rd_beats", rd_count - r0, exp_beats);
        check("rq_empty", rq.size(), 0);
        check("rd_busy_end", busy, 0);
    endtask

    task automatic do_reject(input logic we, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int c0, e0;
        c0 = cs_count; e0 = err_count;
        issue(we, a, l);
        check("rej_cmd_error", cmd_error, 1);
        check("rej_busy", busy, 0);
        tick();
        check("rej_cmd_error_clear", cmd_error, 0);
        repeat (3) tick();
        check("rej_no_cs", cs_count - c0, 0);
        check("rej_err_count", err_count - e0, 1);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
        logic [DW-1:0] seed;
        int            gap;        // write: idle cycles between beats; read: 1 = toggle rd_ready
        int            exp_beats;
        int            exp_span;   // write: cycles from first to last RAM write
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  5'd0, 32'hDEADBEEF, 0, 1, 0};
        vecs[1] = '{1'b1, 5'd30, 5'd3, 32'd1,        0, 4, 3};
        vecs[2] = '{1'b0, 5'd30, 5'd3, 32'd0,        1, 4, 0};
        vecs[3] = '{1'b1, 5'd10, 5'd2, 32'h100,      2, 3, 6};
        vecs[4] = '{1'b0, 5'd10, 5'd2, 32'd0,        0, 3, 0};
        vecs[5] = '{1'b0, 5'd5,  5'd0, 32'd0,        1, 1, 0};

        for (int i = 0; i < 32; i++) ref_mem[i] = 32'hC0DE_0000 + i;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_address = '0; cmd_length = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        #2;
        check("rst_ram_cs", ram_chip_select, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_done", done, 0);
        check("rst_cmd_error", cmd_error, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Reset in the middle of a write burst
        issue(1'b1, 5'd4, 5'd7);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h4000 + i;
            wq.push_back({5'(4 + i), 32'h4000 + DW'(i)});
            ref_mem[4 + i] = 32'h4000 + i;
            tick();
        end
        wr_valid = 1'b0;
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_ram_cs", ram_chip_select, 0);
        check("mid_rst_ram_we", ram_we, 0);
        check("mid_rst_ram_addr", ram_address, 0);
        check("mid_rst_ram_din", ram_data_in, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wr_ready", wr_ready, 0);
        check("mid_rst_wq", wq.size(), 0);
        #1;
        reset_n = 1'b1;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        do_read(5'd4, 5'd7, 0, 8);

        for (int i = 0; i < 6; i++) begin
`ifdef RAM_BURST_BOUND_CHECK_EN
            if (int'(vecs[i].addr) + int'(vecs[i].len) > 31) begin
                do_reject(vecs[i].we, vecs[i].addr, vecs[i].len);
                continue;
            end
`endif
            if (vecs[i].we)
                do_write(vecs[i].addr, vecs[i].len, vecs[i].seed, vecs[i].gap,
                         vecs[i].exp_beats, vecs[i].exp_span);
            else
                do_read(vecs[i].addr, vecs[i].len, vecs[i].gap, vecs[i].exp_beats);
        end
        check("mem5_deadbeef", mem[5], 32'hDEADBEEF);

`ifdef RAM_BURST_BOUND_CHECK_EN
        do_reject(1'b1, 5'd30, 5'd3);
        do_write(5'd28, 5'd3, 32'h2800, 0, 4, 3);
        do_read(5'd28, 5'd3, 1, 4);
`else
        check("no_cmd_error", err_count, 0);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
